// File: rtl/uart_reg_bridge.sv
// Host register bridge: decodes UART command/data bytes into register accesses,
// forwards assembled ECG samples and returns buffered R-peak sample numbers.
module uart_reg_bridge #(
  parameter int DATA_WIDTH = 11,
  parameter int CTR_WIDTH  = 22,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  input  logic [CTR_WIDTH-1:0]  rpeak_loc,
  input  logic                  rpeak_valid,
  output logic                  alg_enable
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] A_SR    = 3'd0;
  localparam logic [2:0] A_CR    = 3'd1;
  localparam logic [2:0] A_DINL  = 3'd2;
  localparam logic [2:0] A_DINH  = 3'd3;
  localparam logic [2:0] A_DOUTL = 3'd4;
  localparam logic [2:0] A_DOUTM = 3'd5;
  localparam logic [2:0] A_DOUTH = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]           addr;
  logic                 cmd_ok, wr_strobe, rd_cmd;
  logic [2:0]           rd_addr;
  logic [7:0]           rd_mux;

  logic [7:0]           dinl;
  logic                 din_pending;
  logic                 overflow;
  logic [23:0]          shadow;
  logic                 shadow_valid;

  logic [CTR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  logic                 empty, full;
  logic [23:0]          head_ext;

  logic                 fifo_clear, sr_rd, doutl_rd, douth_rd;
  logic                 push, pop, ovf_evt;

  function automatic logic [DATA_WIDTH-1:0] assemble(input logic [7:0] hi,
                                                      input logic [7:0] lo);
    return DATA_WIDTH'({hi, lo});
  endfunction

  // Byte decode
  assign cmd_ok    = (state == IDLE) && rx_data_valid && (rx_data[7:4] == 4'h0);
  assign rd_cmd    = cmd_ok && !rx_data[0];
  assign rd_addr   = rx_data[3:1];
  assign wr_strobe = (state == WR_DATA) && rx_data_valid;

  assign fifo_clear = wr_strobe && (addr == A_CR) && rx_data[0];
  assign sr_rd      = rd_cmd && (rd_addr == A_SR);
  assign doutl_rd   = rd_cmd && (rd_addr == A_DOUTL);
  assign douth_rd   = rd_cmd && (rd_addr == A_DOUTH);

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A pop frees a slot in the same edge, so a push into a full FIFO still lands
  assign pop     = douth_rd && shadow_valid && !empty;
  assign push    = rpeak_valid && (!full || pop) && !fifo_clear;
  assign ovf_evt = rpeak_valid && full && !pop && !fifo_clear;

  always_comb begin
    head_ext = '0;
    if (!empty) head_ext[CTR_WIDTH-1:0] = mem[rd_ptr];
  end

  always_comb begin
    rd_mux = 8'h00;
    case (rd_addr)
      A_SR:    rd_mux = {4'h0, din_pending, overflow, full, empty};
      A_CR:    rd_mux = {6'h00, alg_enable, 1'b0};
      A_DOUTL: rd_mux = head_ext[7:0];
      A_DOUTM: rd_mux = shadow[15:8];
      A_DOUTH: rd_mux = shadow[23:16];
      default: rd_mux = 8'h00;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= 3'd0;
    end else begin
      state <= state_nxt;
      if (cmd_ok) addr <= rx_data[3:1];
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_ok) state_nxt = rx_data[0] ? WR_DATA : RD_RESP;
      WR_DATA: if (rx_data_valid) state_nxt = IDLE;
      RD_RESP: if (tx_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs; a response pending while reset is held is never strobed
  always_comb begin
    tx_data_valid = 1'b0;
    if (rst_n && (state == RD_RESP) && tx_ready) tx_data_valid = 1'b1;
  end

  // Read response is frozen at command time
  always_ff @(posedge clk) begin
    if (!rst_n) tx_data <= 8'h00;
    else if (rd_cmd) tx_data <= rd_mux;
  end

  // Control and sample registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alg_enable   <= 1'b0;
      dinl         <= 8'h00;
      din_pending  <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (wr_strobe) begin
        case (addr)
          A_CR:   alg_enable <= rx_data[1];
          A_DINL: begin
            dinl        <= rx_data;
            din_pending <= 1'b1;
          end
          A_DINH: begin
            din_pending <= 1'b0;
            if (alg_enable) begin
              sample_out   <= assemble(rx_data, dinl);
              sample_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Overflow flag: a new overflow outranks the clearing SR read
  always_ff @(posedge clk) begin
    if (!rst_n || fifo_clear) overflow <= 1'b0;
    else if (ovf_evt)         overflow <= 1'b1;
    else if (sr_rd)           overflow <= 1'b0;
  end

  // DOUT shadow
  always_ff @(posedge clk) begin
    if (!rst_n || fifo_clear) begin
      shadow       <= 24'h0;
      shadow_valid <= 1'b0;
    end else if (doutl_rd) begin
      shadow       <= head_ext;
      shadow_valid <= !empty;
    end else if (pop) begin
      shadow_valid <= 1'b0;
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n || fifo_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rpeak_loc;
  end

endmodule
